// File: rtl/alu_issue_sequencer.sv
// Issue sequencer in front of the 8-bit combinational ALU: accepts one instruction per
// handshake, reads operands from an 8-entry register file, captures the ALU result and writes it back.
package alu_issue_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  typedef struct packed {
    logic       li;
    logic [2:0] op;
    logic [2:0] rd;
    logic [2:0] ra;
    logic [2:0] rb;
    logic [2:0] lo;
  } instr_t;

endpackage

module alu_issue_sequencer
  import alu_issue_sequencer_pkg::*;
#(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          instr_valid,
  output logic          instr_ready,
  input  logic [15:0]   instr,
  output logic [DW-1:0] alu_in1,
  output logic [DW-1:0] alu_in2,
  output logic [2:0]    alu_sel,
  input  logic [DW-1:0] alu_out,
  input  logic          alu_z,
  output logic          z_flag,
  output logic          done,
  input  logic [AW-1:0] dbg_addr,
  output logic [DW-1:0] dbg_data
);

  localparam int unsigned NREG = 2 ** AW;

  state_t        state;
  state_t        state_nxt;
  instr_t        ir;
  instr_t        instr_f;
  logic [7:0]    ir_imm;
  logic [DW-1:0] rf [NREG];
  logic [DW-1:0] res;
  logic          res_z;
  logic          accept_c;

  assign instr_f  = instr_t'(instr);
  // The immediate shares bits [7:0] with the ra/rb fields.
  assign ir_imm   = {ir.ra[1:0], ir.rb, ir.lo};
  assign dbg_data = rf[dbg_addr];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake decode.
  always_comb begin
    state_nxt   = state;
    instr_ready = 1'b0;
    accept_c    = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = !reset;
        accept_c    = instr_valid && !reset;
        if (accept_c) begin
          state_nxt = instr_f.li ? WB : EXEC;
        end
      end
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: ALU drive is loaded on the way into EXEC so it is only non-zero during EXEC.
  always_ff @(posedge clk) begin
    if (reset) begin
      ir      <= '0;
      res     <= '0;
      res_z   <= 1'b0;
      z_flag  <= 1'b0;
      done    <= 1'b0;
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_sel <= '0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      done    <= (state_nxt == WB);
      alu_in1 <= '0;
      alu_in2 <= '0;
      alu_sel <= '0;
      if (accept_c) begin
        ir <= instr_f;
      end
      if (state_nxt == EXEC) begin
        alu_in1 <= rf[AW'(instr_f.ra)];
        alu_in2 <= rf[AW'(instr_f.rb)];
        alu_sel <= instr_f.op;
      end
      if (state == EXEC) begin
        res   <= alu_out;
        res_z <= alu_z;
      end
      if (state == WB) begin
        if (ir.li) begin
          rf[AW'(ir.rd)] <= DW'(ir_imm);
        end else begin
          rf[AW'(ir.rd)] <= res;
          z_flag         <= res_z;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_sequencer.sv
// Directed self-checking bench for alu_issue_sequencer; the ALU is replaced by a
// stub whose output and zero flag are set per step.
module tb_alu_issue_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = '0;
  logic [7:0]  alu_in1;
  logic [7:0]  alu_in2;
  logic [2:0]  alu_sel;
  logic [7:0]  alu_out = '0;
  logic        alu_z = 1'b0;
  logic        z_flag;
  logic        done;
  logic [2:0]  dbg_addr = '0;
  logic [7:0]  dbg_data;

  int          checks = 0;
  int          failures = 0;
  logic        exp_z = 1'b0;
  int          idx = 0;
  logic        acc = 1'b0;
  logic [15:0] q [3];

  alu_issue_sequencer #(.DW(8), .AW(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_sel     (alu_sel),
    .alu_out     (alu_out),
    .alu_z       (alu_z),
    .z_flag      (z_flag),
    .done        (done),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rchk(input string tag, input logic [2:0] a, input logic [7:0] e);
    dbg_addr = a;
    #1;
    chk(tag, 32'(dbg_data), 32'(e));
  endtask

  task automatic do_li(input logic [2:0] rd, input logic [7:0] imm);
    instr       = {1'b1, 3'b000, rd, 1'b0, imm};
    instr_valid = 1'b1;
    chk("li_ready", 32'(instr_ready), 1);
    step();
    instr_valid = 1'b0;
    chk("li_wb_done", 32'(done), 1);
    chk("li_wb_sel", 32'(alu_sel), 0);
    chk("li_wb_ready", 32'(instr_ready), 0);
    step();
    chk("li_idle_done", 32'(done), 0);
    chk("li_idle_ready", 32'(instr_ready), 1);
    chk("li_zflag", 32'(z_flag), 32'(exp_z));
    rchk("li_write", rd, imm);
  endtask

  task automatic do_alu(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                        input logic [2:0] rb, input logic [7:0] res, input logic z,
                        input logic [7:0] e1, input logic [7:0] e2);
    instr       = {1'b0, op, rd, ra, rb, 3'b000};
    instr_valid = 1'b1;
    alu_out     = res;
    alu_z       = z;
    chk("alu_ready", 32'(instr_ready), 1);
    step();
    instr_valid = 1'b0;
    chk("exec_in1", 32'(alu_in1), 32'(e1));
    chk("exec_in2", 32'(alu_in2), 32'(e2));
    chk("exec_sel", 32'(alu_sel), 32'(op));
    chk("exec_ready", 32'(instr_ready), 0);
    chk("exec_done", 32'(done), 0);
    step();
    chk("wb_done", 32'(done), 1);
    chk("wb_in1", 32'(alu_in1), 0);
    chk("wb_sel", 32'(alu_sel), 0);
    chk("wb_ready", 32'(instr_ready), 0);
    step();
    exp_z = z;
    chk("alu_idle_done", 32'(done), 0);
    chk("alu_idle_ready", 32'(instr_ready), 1);
    chk("alu_zflag", 32'(z_flag), 32'(exp_z));
    rchk("alu_write", rd, res);
  endtask

  initial begin
    // Reset values while reset is held
    step();
    step();
    chk("rst_ready", 32'(instr_ready), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_zflag", 32'(z_flag), 0);
    chk("rst_in1", 32'(alu_in1), 0);
    chk("rst_in2", 32'(alu_in2), 0);
    chk("rst_sel", 32'(alu_sel), 0);
    rchk("rst_r0", 3'd0, 8'h00);
    rchk("rst_r7", 3'd7, 8'h00);
    reset = 1'b0;
    #1;
    chk("rel_ready", 32'(instr_ready), 1);

    // Load immediate 16'h8205
    do_li(3'd1, 8'h05);

    // ADD-style op, stub returns 6
    do_li(3'd1, 8'h02);
    do_li(3'd2, 8'h04);
    do_alu(3'b000, 3'd3, 3'd1, 3'd2, 8'h06, 1'b0, 8'h02, 8'h04);

    // Zero result sets the flag
    do_li(3'd1, 8'h01);
    do_li(3'd2, 8'h03);
    do_alu(3'b100, 3'd4, 3'd1, 3'd2, 8'h00, 1'b1, 8'h01, 8'h03);
    rchk("r3_kept", 3'd3, 8'h06);

    // rd == ra uses the old operand value
    do_li(3'd1, 8'h05);
    do_li(3'd2, 8'h03);
    do_alu(3'b001, 3'd1, 3'd1, 3'd2, 8'h08, 1'b0, 8'h05, 8'h03);

    // Reset during EXEC aborts the write
    instr       = {1'b0, 3'b000, 3'd5, 3'd1, 3'd2, 3'b000};
    instr_valid = 1'b1;
    alu_out     = 8'hAA;
    alu_z       = 1'b0;
    step();
    instr_valid = 1'b0;
    chk("mr_exec_in1", 32'(alu_in1), 32'h08);
    reset = 1'b1;
    step();
    chk("mr_ready_rst", 32'(instr_ready), 0);
    chk("mr_done_rst", 32'(done), 0);
    chk("mr_in1_rst", 32'(alu_in1), 0);
    reset = 1'b0;
    #1;
    chk("mr_ready_rel", 32'(instr_ready), 1);
    step();
    chk("mr_done_after", 32'(done), 0);
    chk("mr_ready_after", 32'(instr_ready), 1);
    rchk("mr_r5", 3'd5, 8'h00);
    rchk("mr_r1", 3'd1, 8'h00);

    // Three queued ALU instructions with instr_valid held high
    q[0] = {1'b0, 3'b010, 3'd5, 3'd1, 3'd2, 3'b000};
    q[1] = {1'b0, 3'b011, 3'd6, 3'd1, 3'd2, 3'b000};
    q[2] = {1'b0, 3'b101, 3'd7, 3'd1, 3'd2, 3'b000};
    alu_z = 1'b0;
    idx   = 0;
    for (int c = 0; c < 12; c++) begin
      instr_valid = (idx < 3);
      instr       = q[(idx < 3) ? idx : 2];
      alu_out     = 8'h20 + 8'(idx);
      #1;
      chk("q_ready", 32'(instr_ready), (c < 9) ? 32'(c % 3 == 0) : 1);
      chk("q_done", 32'(done), 32'((c < 9) && (c % 3 == 2)));
      acc = instr_valid && instr_ready;
      step();
      if (acc) idx++;
    end
    instr_valid = 1'b0;
    chk("q_accepts", 32'(idx), 3);
    rchk("q_r5", 3'd5, 8'h21);
    rchk("q_r6", 3'd6, 8'h22);
    rchk("q_r7", 3'd7, 8'h23);
    chk("q_zflag", 32'(z_flag), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_sequencer.md
Name: alu_issue_sequencer

Overview:
- Upstream control/datapath stage for the 8-bit combinational `alu`; drives its `in1`, `in2` and `sel` inputs.
- Accepts one 16-bit instruction per valid/ready handshake.
- Reads two operands from an internal 8x8 register file and presents them to the ALU for one cycle.
- Captures the ALU's `out`/`Z` and writes the result back to the register file and a zero flag. Also supports load-immediate.

Parameters:
- DW, 8, data width; must match the ALU operand width.
- AW, 3, register address width; the register file has 2**AW entries.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- instr_valid  input  1  upstream has an instruction on `instr`.
- instr_ready  output  1  sequencer can accept an instruction this cycle.
- instr  input  16  instruction word.
  - [15] li
  - [14:12] op
  - [11:9] rd
  - [8:6] ra
  - [5:3] rb
  - [7:0] imm (used only when li=1)
- alu_in1  output  DW  to ALU `in1`.
- alu_in2  output  DW  to ALU `in2`.
- alu_sel  output  3  to ALU `sel`.
- alu_out  input  DW  from ALU `out`.
- alu_z  input  1  from ALU `Z`.
- z_flag  output  1  registered zero flag from the last ALU instruction.
- done  output  1  one-cycle pulse in the cycle of each register write-back.
- dbg_addr  input  AW  debug read address.
- dbg_data  output  DW  combinational read of R[dbg_addr].

Behaviour:
- Clock and reset: single clock `clk`; `reset` is synchronous and active-high.
- Reset values:
  - R[0..7] = 0, z_flag = 0, done = 0, state = IDLE.
  - Internal IR and result registers = 0.
  - instr_ready = 0 while reset is high.
  - alu_in1 = alu_in2 = 0, alu_sel = 0.
- States: IDLE, EXEC, WB.
- IDLE:
  - instr_ready = 1.
  - On instr_valid & instr_ready at edge k: IR <= instr.
  - Next state is EXEC if li=0, or WB if li=1.
  - instr_valid without acceptance has no effect; instr may change freely while instr_ready=0.
- EXEC (exactly one cycle):
  - instr_ready = 0.
  - alu_in1 = R[IR.ra], alu_in2 = R[IR.rb], alu_sel = IR.op.
  - At the end of the cycle, the result register <= alu_out and the Z register <= alu_z.
  - Next state WB.
- WB (exactly one cycle):
  - instr_ready = 0, done = 1.
  - At the end of the cycle:
    - li=0: R[IR.rd] <= captured result; z_flag <= captured Z.
    - li=1: R[IR.rd] <= IR.imm; z_flag unchanged.
  - Next state IDLE.
- ALU drive outside EXEC: alu_in1, alu_in2 and alu_sel are forced to 0 in all other states. The bench checks this.
- Latency:
  - ALU instruction accepted at edge k: operands valid during cycle k..k+1; write visible on dbg_data after edge k+2; instr_ready high again after edge k+2.
  - LI instruction: write visible after edge k+1.
- Throughput: one ALU instruction per 3 cycles; one LI per 2 cycles. No back-to-back overlap.
- Hazards: rd may equal ra or rb. Operands are read in EXEC before the write in WB, so the old value is used. No forwarding is needed.
- Width: all register values are DW bits. The sequencer performs no arithmetic; it passes ALU results through unchanged.
- Reset mid-operation: reset asserted in EXEC or WB aborts the instruction. No register write occurs at that edge; all state returns to reset values.
- Concurrent accept: instr_valid held high across a WB cycle is accepted only in the following IDLE cycle.

Test Plan:
- Reset, then LI instr 16'h8205 (rd=1, imm=5) -> done pulse 1 cycle after accept; dbg_addr=1 reads 8'h05; z_flag stays 0.
- LI R1=2, LI R2=4, then ALU op=000 rd=3 ra=1 rb=2; ALU stub returns 8'h06, Z=0 -> during EXEC alu_in1=2, alu_in2=4, alu_sel=000; R3=8'h06, z_flag=0 two edges after accept.
- LI R1=1, LI R2=3, ALU op=100 rd=4 ra=1 rb=2; stub returns 8'h00, Z=1 -> alu_sel=100 during EXEC only; R4=0, z_flag=1.
- instr_valid held high with 3 queued instructions -> instr_ready low in EXEC/WB; exactly 3 accepts; done pulses spaced 3 cycles apart for ALU ops.
- rd=ra=1 (R1=5, R2=3), stub returns 8'h08 -> ALU saw in1=5; R1=8 after WB.
- reset asserted during EXEC of an ALU op targeting R5 -> R5 stays 0, no done pulse, instr_ready=1 one cycle after reset deasserts.
